// File: rtl/cmd_write_mesh.sv
// cmd_write_mesh: loads one vertex or edge RAM word per accepted write frame.
// Frame bytes: addr hi, addr lo, then N data bytes MSB first.
// The word is committed after frame_ok, and only while the draw engine is idle.
//
// Ports:
//   CLK, rst_n           clock; asynchronous active-low reset
//   cmd_valid/opcode     start of frame and its opcode (0x04 vertex, 0x05 edge)
//   byte_valid/data      payload byte stream
//   frame_ok/abort       end of frame: good CRC / rejected
//   draw_busy            draw engine busy; holds the RAM write off
//   *_VERTEX, *_EDGE     RAM write ports (ADDR, DIN, WE)
//   BUSY, DONE, ERR      frame in progress, write pulse, reject pulse
module cmd_write_mesh #(
    parameter int DEPTH     = 1024,
    parameter int DW_VERTEX = 64,
    parameter int DW_EDGE   = 48,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [7:0]           cmd_opcode,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 frame_ok,
    input  logic                 frame_abort,
    input  logic                 draw_busy,
    output logic [ADDR_W-1:0]    ADDR_VERTEX,
    output logic [DW_VERTEX-1:0] DIN_VERTEX,
    output logic                 WE_VERTEX,
    output logic [ADDR_W-1:0]    ADDR_EDGE,
    output logic [DW_EDGE-1:0]   DIN_EDGE,
    output logic                 WE_EDGE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam int NV   = DW_VERTEX / 8;
    localparam int NE   = DW_EDGE / 8;
    localparam int NMAX = (NV > NE) ? NV : NE;
    localparam int DMAX = NMAX * 8;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_WAIT_CRC,
        S_COMMIT,
        S_REJECT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]           rst_sync;
    logic                 rst_sync_n;
    logic                 is_edge;
    logic [15:0]          addr_r;
    logic [DMAX-1:0]      data_r;
    logic [CW-1:0]        cnt;
    logic [ADDR_W-1:0]    hold_addr_v;
    logic [DW_VERTEX-1:0] hold_din_v;
    logic [ADDR_W-1:0]    hold_addr_e;
    logic [DW_EDGE-1:0]   hold_din_e;

    logic ld_type;
    logic ld_hi;
    logic ld_lo;
    logic shift;
    logic we_v;
    logic we_e;
    logic addr_ok;
    logic op_write;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync[1];

    assign addr_ok  = {16'd0, addr_r} < 32'(DEPTH);
    assign op_write = (cmd_opcode == 8'h04) || (cmd_opcode == 8'h05);

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld_type  = 1'b0;
        ld_hi    = 1'b0;
        ld_lo    = 1'b0;
        shift    = 1'b0;
        we_v     = 1'b0;
        we_e     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid && op_write) begin
                    ld_type  = 1'b1;
                    state_nx = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (frame_abort || frame_ok) begin
                    state_nx = S_REJECT;
                end else if (byte_valid) begin
                    ld_hi    = 1'b1;
                    state_nx = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (frame_abort || frame_ok) begin
                    state_nx = S_REJECT;
                end else if (byte_valid) begin
                    ld_lo    = 1'b1;
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_abort || frame_ok) begin
                    state_nx = S_REJECT;
                end else if (byte_valid) begin
                    shift = 1'b1;
                    if (cnt == '0) begin
                        state_nx = S_WAIT_CRC;
                    end
                end
            end
            S_WAIT_CRC: begin
                if (frame_abort) begin
                    state_nx = S_REJECT;
                end else if (frame_ok) begin
                    // Out-of-range addresses are rejected, never clamped.
                    state_nx = addr_ok ? S_COMMIT : S_REJECT;
                end else if (byte_valid) begin
                    state_nx = S_REJECT;
                end
            end
            S_COMMIT: begin
                if (frame_abort) begin
                    state_nx = S_REJECT;
                end else if (!draw_busy) begin
                    we_v     = !is_edge;
                    we_e     = is_edge;
                    state_nx = S_IDLE;
                end
            end
            S_REJECT: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            is_edge <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            cnt     <= '0;
        end else if (state_nx == S_IDLE) begin
            addr_r <= '0;
            data_r <= '0;
            cnt    <= '0;
        end else begin
            if (ld_type) begin
                is_edge <= (cmd_opcode == 8'h05);
            end
            if (ld_hi) begin
                addr_r[15:8] <= byte_data;
            end
            if (ld_lo) begin
                addr_r[7:0] <= byte_data;
                cnt <= is_edge ? CW'(NE - 1) : CW'(NV - 1);
            end
            if (shift) begin
                data_r <= (data_r << 8) | DMAX'(byte_data);
                cnt    <= cnt - CW'(1);
            end
        end
    end

    // Each RAM port keeps its last written address/data between writes.
    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            hold_addr_v <= '0;
            hold_din_v  <= '0;
            hold_addr_e <= '0;
            hold_din_e  <= '0;
        end else begin
            if (we_v) begin
                hold_addr_v <= addr_r[ADDR_W-1:0];
                hold_din_v  <= data_r[DW_VERTEX-1:0];
            end
            if (we_e) begin
                hold_addr_e <= addr_r[ADDR_W-1:0];
                hold_din_e  <= data_r[DW_EDGE-1:0];
            end
        end
    end

    assign ADDR_VERTEX = we_v ? addr_r[ADDR_W-1:0] : hold_addr_v;
    assign DIN_VERTEX  = we_v ? data_r[DW_VERTEX-1:0] : hold_din_v;
    assign WE_VERTEX   = we_v;
    assign ADDR_EDGE   = we_e ? addr_r[ADDR_W-1:0] : hold_addr_e;
    assign DIN_EDGE    = we_e ? data_r[DW_EDGE-1:0] : hold_din_e;
    assign WE_EDGE     = we_e;
    assign BUSY        = (state != S_IDLE);
    assign DONE        = we_v | we_e;
    assign ERR         = (state == S_REJECT);

endmodule
